mips_bus_arbiter: RTL

//  Shares the single Avalon-style memory bus (address/read/write/writedata/byteenable/

---
 rtl/mips_bus_pkg.sv | 32 +++
 rtl/mips_bus_watchdog.sv | 27 ++
 rtl/mips_bus_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the I/D memory bus arbiter.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        M_I = 1'b0,
        M_D = 1'b1
    } master_t;

    localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;
    localparam logic [3:0]  BE_FULL    = 4'b1111;

    // Round-robin pick among pending masters; on a tie the master that was not served last wins.
    function automatic arb_state_t arb_pick(input logic i_pend, input logic d_pend, input master_t last);
        arb_state_t pick;
        pick = IDLE;
        if (i_pend && d_pend) begin
            pick = (last == M_D) ? BUSY_I : BUSY_D;
        end else if (i_pend) begin
            pick = BUSY_I;
        end else if (d_pend) begin
            pick = BUSY_D;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mips_bus_watchdog.sv
// Stall counter for one bus transaction; flags when the slave has stalled MAX_WAIT cycles.
module mips_bus_watchdog #(
    parameter int MAX_WAIT = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

    logic [CW-1:0] count;

    // Count stall cycles, saturating at the limit so the flag stays asserted.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (tick && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/mips_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-style bus between the fetch (I) and data (D) ports.
//
//  state  | meaning
//  IDLE   | no owner, bus strobes low
//  BUSY_I | fetch port owns the bus until completion or abort
//  BUSY_D | data port owns the bus until completion or abort
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int MAX_WAIT = 256,
    parameter int AW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] i_address,
    input  logic          i_read,
    output logic          i_waitrequest,
    output logic [31:0]   i_readdata,
    input  logic [AW-1:0] d_address,
    input  logic          d_read,
    input  logic          d_write,
    input  logic [31:0]   d_writedata,
    input  logic [3:0]    d_byteenable,
    output logic          d_waitrequest,
    output logic [31:0]   d_readdata,
    output logic [AW-1:0] address,
    output logic          read,
    output logic          write,
    output logic [31:0]   writedata,
    output logic [3:0]    byteenable,
    input  logic          waitrequest,
    input  logic [31:0]   readdata,
    output logic [1:0]    grant,
    output logic          timeout_err
);
    arb_state_t state;
    arb_state_t state_next;
    master_t    last;
    logic       i_pend;
    logic       d_pend;
    logic       busy;
    logic       expired;
    logic       abort;
    logic       done;

    assign i_pend = i_read;
    assign d_pend = d_read | d_write;
    assign busy   = (state != IDLE);
    // A reset cycle never signals completion, even if the slave happens to release.
    assign abort  = busy && expired && !reset;
    assign done   = busy && !reset && (expired || !waitrequest);

    mips_bus_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (!busy || done),
        .tick    (busy && waitrequest),
        .expired (expired)
    );

    // State, round-robin pointer and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last        <= M_D;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            if (done) begin
                last <= (state == BUSY_I) ? M_I : M_D;
            end
            if (abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Next owner: hand over straight to the other master on completion, idle after an abort.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                state_next = arb_pick(i_pend, d_pend, last);
            end
            BUSY_I: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (done) begin
                    state_next = d_pend ? BUSY_D : IDLE;
                end
            end
            BUSY_D: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (done) begin
                    state_next = i_pend ? BUSY_I : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus and master-side outputs muxed from the current owner.
    always_comb begin
        address       = '0;
        read          = 1'b0;
        write         = 1'b0;
        writedata     = '0;
        byteenable    = '0;
        grant         = 2'b00;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        i_readdata    = readdata;
        d_readdata    = readdata;
        case (state)
            BUSY_I: begin
                grant      = 2'b01;
                address    = i_address;
                read       = 1'b1;
                byteenable = BE_FULL;
                if (done) begin
                    i_waitrequest = 1'b0;
                    if (abort) begin
                        i_readdata = ABORT_DATA;
                    end
                end
            end
            BUSY_D: begin
                grant      = 2'b10;
                address    = d_address;
                write      = d_write;
                read       = d_read & ~d_write;
                writedata  = d_writedata;
                byteenable = d_byteenable;
                if (done) begin
                    d_waitrequest = 1'b0;
                    if (abort) begin
                        d_readdata = ABORT_DATA;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule
